i2s_tx_pkt_packer: RTL and testbench

- Upstream stage of the USB isochronous IN packet FIFO (sync_tx_pkt_fifo).
- Takes stereo PCM frames from the I2S receiver and serialises them into little-endian bytes, left channel first, one byte per cycle.
- Writes each byte into the FIFO's byte write port.
- Uses the FIFO's wrnum and full to decide per frame whether to accept or drop. The I2S side cannot stall, so frames that do not fit are dropped, never split.

---
 rtl/i2s_usb_pkg.sv | 22 ++
 rtl/i2s_tx_pkt_packer_if.sv | 12 +
 rtl/i2s_frame_serializer.sv | 114 +++++++++++
 rtl/i2s_tx_pkt_packer.sv | 81 ++++++++
 tb/tb_i2s_tx_pkt_packer.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_usb_pkg.sv
// Shared constants, FSM encoding and helpers for the I2S -> USB isochronous packer path.
package i2s_usb_pkg;

    localparam int SWIDTH_ALLOWED [3] = '{16, 24, 32};
    localparam int SPACE_MARGIN = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } pkr_state_e;

    // Bytes per stereo frame; an unsupported width yields 0 so the build breaks loudly.
    function automatic int nb_of(input int swidth);
        int nb;
        nb = 0;
        for (int i = 0; i < 3; i++) begin
            if (swidth == SWIDTH_ALLOWED[i]) nb = swidth / 4;
        end
        return nb;
    endfunction

endpackage

// File: rtl/i2s_tx_pkt_packer_if.sv
// Byte write port between the packer and the isochronous IN packet FIFO.
interface i2s_tx_pkt_packer_if #(
    parameter int ASIZE = 9
) ();
    logic             write;
    logic [7:0]       oData;
    logic [ASIZE:0]   wrnum;
    logic             full;

    modport master (output write, output oData, input wrnum, input full);
    modport slave  (input write, input oData, output wrnum, output full);
endinterface

// File: rtl/i2s_frame_serializer.sv
// Shifts one stereo frame out LSB first, one byte per cycle, with a one-frame hold slot
// so consecutive frames are written back-to-back.
module i2s_frame_serializer
    import i2s_usb_pkg::*;
#(
    parameter int SWIDTH = 24
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  enable,
    input  logic                  full,
    input  logic                  accept,
    input  logic [2*SWIDTH-1:0]   frame,
    output logic                  write,
    output logic [7:0]            odata,
    output logic                  busy,
    output logic                  idle,
    output logic                  hold_valid,
    output logic                  frame_done
);
    localparam int NB = nb_of(SWIDTH);
    localparam int FW = 2 * SWIDTH;
    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] CNT_LOAD = CW'(NB - 1);

    pkr_state_e     state_q, state_d;
    logic [FW-1:0]  shift_q, shift_d, hold_q, hold_d, cur_shift;
    logic [CW-1:0]  cnt_q, cnt_d, cur_cnt;
    logic           hold_valid_q, hold_valid_d;
    logic           write_q, write_d;
    logic [7:0]     odata_q, odata_d;
    logic           cur_active, take_next;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        write_d      = 1'b0;
        odata_d      = odata_q;
        frame_done   = 1'b0;
        take_next    = 1'b0;
        cur_active   = 1'b0;
        cur_shift    = shift_q;
        cur_cnt      = cnt_q;

        // A frame accepted from IDLE is presented on the same edge to reach t+1 latency.
        if (state_q == ST_SEND) begin
            cur_active = 1'b1;
        end else if (accept) begin
            cur_active = 1'b1;
            cur_shift  = frame;
            cur_cnt    = CNT_LOAD;
        end

        if (state_q == ST_SEND && accept) begin
            hold_d       = frame;
            hold_valid_d = 1'b1;
        end
        if (!enable) hold_valid_d = 1'b0;

        if (cur_active) begin
            state_d = ST_SEND;
            shift_d = cur_shift;
            cnt_d   = cur_cnt;
            if (!full) begin
                write_d = 1'b1;
                odata_d = cur_shift[7:0];
                if (cur_cnt == '0) begin
                    frame_done = 1'b1;
                    take_next  = enable && (hold_valid_q || (state_q == ST_SEND && accept));
                    if (take_next) begin
                        shift_d      = hold_valid_q ? hold_q : frame;
                        cnt_d        = CNT_LOAD;
                        hold_valid_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    shift_d = cur_shift >> 8;
                    cnt_d   = cur_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            write_q      <= 1'b0;
            odata_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            write_q      <= write_d;
            odata_q      <= odata_d;
        end
    end

    assign write      = write_q;
    assign odata      = odata_q;
    assign idle       = (state_q == ST_IDLE);
    assign hold_valid = hold_valid_q;
    assign busy       = (state_q == ST_SEND) | hold_valid_q;

endmodule

// File: rtl/i2s_tx_pkt_packer.sv
// I2S stereo frame packer feeding the USB isochronous IN FIFO; whole frames are dropped when
// the FIFO lacks room. Optional drop counter under I2S_PACKER_DROPCNT_EN.
module i2s_tx_pkt_packer
    import i2s_usb_pkg::*;
#(
    parameter int SWIDTH = 24,
    parameter int ASIZE  = 9
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 enable,
    input  logic                 sample_valid,
    input  logic [SWIDTH-1:0]    iLeft,
    input  logic [SWIDTH-1:0]    iRight,
    i2s_tx_pkt_packer_if.master  fifo,
    output logic                 busy,
    output logic [15:0]          frame_cnt
`ifdef I2S_PACKER_DROPCNT_EN
    ,
    output logic [15:0]          drop_cnt
`endif
);
    localparam int NB = nb_of(SWIDTH);
    localparam logic [ASIZE+1:0] DEPTH = (ASIZE + 2)'(1) << ASIZE;
    localparam logic [ASIZE+1:0] NEED  = (ASIZE + 2)'(2 * NB + SPACE_MARGIN);

    logic [ASIZE+1:0] free;
    logic             space_ok, accept, idle, hold_valid, frame_done;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    // wrnum lags a write by a cycle, so the margin keeps one extra frame of headroom.
    assign free     = DEPTH - {1'b0, fifo.wrnum};
    assign space_ok = (free >= NEED);
    assign accept   = enable & sample_valid & space_ok & (idle | ~hold_valid);

    i2s_frame_serializer #(
        .SWIDTH (SWIDTH)
    ) u_serializer (
        .clk        (CLK),
        .srst       (RST),
        .enable     (enable),
        .full       (fifo.full),
        .accept     (accept),
        .frame      ({iRight, iLeft}),
        .write      (fifo.write),
        .odata      (fifo.oData),
        .busy       (busy),
        .idle       (idle),
        .hold_valid (hold_valid),
        .frame_done (frame_done)
    );

    always_comb frame_cnt_d = frame_cnt_q + {15'd0, frame_done};

    always_ff @(posedge CLK) begin
        if (RST) frame_cnt_q <= 16'd0;
        else     frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;

`ifdef I2S_PACKER_DROPCNT_EN
    logic        reject;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign reject = enable & sample_valid & ~accept;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (reject && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) drop_cnt_q <= 16'd0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx_pkt_packer.sv
// Directed scenarios plus a randomized run against a byte-queue reference model.
module tb_i2s_tx_pkt_packer;
    localparam int SWIDTH = 24;
    localparam int ASIZE  = 9;
    localparam int NB     = 6;
    localparam int DEPTH  = 512;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enable;
    logic        sample_valid;
    logic [23:0] iLeft, iRight;
    logic        busy;
    logic [15:0] frame_cnt;
`ifdef I2S_PACKER_DROPCNT_EN
    logic [15:0] drop_cnt;
`endif

    i2s_tx_pkt_packer_if #(.ASIZE(ASIZE)) fifo ();

    i2s_tx_pkt_packer #(.SWIDTH(SWIDTH), .ASIZE(ASIZE)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .enable       (enable),
        .sample_valid (sample_valid),
        .iLeft        (iLeft),
        .iRight       (iRight),
        .fifo         (fifo.master),
        .busy         (busy),
        .frame_cnt    (frame_cnt)
`ifdef I2S_PACKER_DROPCNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_a [6] = '{8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB};
    logic [7:0] exp_b [6] = '{8'h21, 8'h43, 8'h65, 8'hCB, 8'hED, 8'h0F};
    logic [7:0] exp_c [6] = '{8'hEE, 8'hFF, 8'hC0, 8'h01, 8'h00, 8'h00};

    // Reference model: bytes still owed to the FIFO, with end-of-frame markers.
    logic [7:0]  mq [$];
    bit          ml [$];
    int          m_frames = 0;
    logic        m_write = 1'b0;
    logic [7:0]  m_odata = 8'h00;
    logic [15:0] m_fcnt = 16'd0;
    logic [15:0] m_dcnt = 16'd0;
    logic        m_busy = 1'b0;

    logic [8:0]  wr_trace [$];

    task automatic step();
        int          free;
        logic [47:0] f;
        @(posedge CLK);
        if (RST) begin
            mq.delete();
            ml.delete();
            m_frames = 0;
            m_write  = 1'b0;
            m_odata  = 8'h00;
            m_fcnt   = 16'd0;
            m_dcnt   = 16'd0;
        end else begin
            free = DEPTH - int'(fifo.wrnum);
            if (!enable && m_frames == 2) begin
                for (int i = 0; i < NB; i++) begin
                    void'(mq.pop_back());
                    void'(ml.pop_back());
                end
                m_frames = 1;
            end
            if (enable && sample_valid) begin
                if (free >= 2 * NB + 2 && m_frames < 2) begin
                    f = {iRight, iLeft};
                    for (int i = 0; i < NB; i++) begin
                        mq.push_back(f[8*i +: 8]);
                        ml.push_back(i == NB - 1);
                    end
                    m_frames++;
                end else if (m_dcnt != 16'hFFFF) begin
                    m_dcnt++;
                end
            end
            m_write = 1'b0;
            if (mq.size() > 0 && !fifo.full) begin
                m_write = 1'b1;
                m_odata = mq.pop_front();
                if (ml.pop_front()) begin
                    m_frames--;
                    m_fcnt++;
                    $display("frame complete: model frame_cnt=%0d at %0t", m_fcnt, $time);
                end
            end
        end
        m_busy = (m_frames > 0);
        #1;
        wr_trace.push_back({fifo.write, (fifo.write === 1'b1) ? fifo.oData : 8'h00});
    endtask

    task automatic reset_dut();
        RST = 1'b1;
        sample_valid = 1'b0;
        step();
        step();
        RST = 1'b0;
        wr_trace.delete();
    endtask

    task automatic test_reset();
        RST = 1'b1; enable = 1'b1; sample_valid = 1'b0;
        iLeft = 24'h0; iRight = 24'h0; fifo.wrnum = '0; fifo.full = 1'b0;
        step();
        step();
        n_checks++; if (fifo.write !== 1'b0) begin n_fail++; $display("FAIL reset_write got=%b want=0", fifo.write); end
        n_checks++; if (fifo.oData !== 8'h00) begin n_fail++; $display("FAIL reset_odata got=%h want=00", fifo.oData); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
`ifdef I2S_PACKER_DROPCNT_EN
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
`endif
        RST = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [8:0] want;
        reset_dut();
        iLeft = 24'h123456; iRight = 24'hABCDEF; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (8) step();
        for (int i = 0; i < 9; i++) begin
            if (i < 6) want = {1'b1, exp_a[i]};
            else       want = 9'h000;
            n_checks++;
            if (wr_trace[i] !== want) begin n_fail++; $display("FAIL single_byte[%0d] got=%h want=%h", i, wr_trace[i], want); end
        end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL single_frame_cnt got=%0d want=1", frame_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got=%b want=0", busy); end
        $display("test_single: frame L=123456 R=ABCDEF sent");
    endtask

    task automatic test_back_to_back();
        logic [8:0] want;
        reset_dut();
        iLeft = 24'h123456; iRight = 24'hABCDEF; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        step();
        iLeft = 24'h654321; iRight = 24'h0FEDCB; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (12) step();
        for (int i = 0; i < 15; i++) begin
            if (i < 6)       want = {1'b1, exp_a[i]};
            else if (i < 12) want = {1'b1, exp_b[i-6]};
            else             want = 9'h000;
            n_checks++;
            if (wr_trace[i] !== want) begin n_fail++; $display("FAIL b2b_byte[%0d] got=%h want=%h", i, wr_trace[i], want); end
        end
        n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_frame_cnt got=%0d want=2", frame_cnt); end
        $display("test_back_to_back: two frames via hold register");
    endtask

    task automatic test_no_space();
        logic [8:0] want;
        reset_dut();
        fifo.wrnum = 10'(DEPTH - 13);
        iLeft = 24'h123456; iRight = 24'hABCDEF; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (7) step();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (wr_trace[i] !== 9'h000) begin n_fail++; $display("FAIL nospace_write[%0d] got=%h want=000", i, wr_trace[i]); end
        end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL nospace_frame_cnt got=%0d want=0", frame_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nospace_busy got=%b want=0", busy); end
`ifdef I2S_PACKER_DROPCNT_EN
        n_checks++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL nospace_drop_cnt got=%0d want=1", drop_cnt); end
`endif
        // Exactly 2*NB+2 bytes free is enough.
        fifo.wrnum = 10'(DEPTH - 14);
        wr_trace.delete();
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 7; i++) begin
            if (i < 6) want = {1'b1, exp_a[i]};
            else       want = 9'h000;
            n_checks++;
            if (wr_trace[i] !== want) begin n_fail++; $display("FAIL edge_space_byte[%0d] got=%h want=%h", i, wr_trace[i], want); end
        end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL edge_space_frame_cnt got=%0d want=1", frame_cnt); end
        fifo.wrnum = '0;
        $display("test_no_space: free=13 dropped, free=14 accepted");
    endtask

    task automatic test_full_stall();
        logic [8:0] want;
        reset_dut();
        iLeft = 24'h123456; iRight = 24'hABCDEF; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (2) step();
        fifo.full = 1'b1;
        repeat (5) step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy got=%b want=1", busy); end
        fifo.full = 1'b0;
        repeat (5) step();
        for (int i = 0; i < 13; i++) begin
            if (i < 3)       want = {1'b1, exp_a[i]};
            else if (i < 8)  want = 9'h000;
            else if (i < 11) want = {1'b1, exp_a[i-5]};
            else             want = 9'h000;
            n_checks++;
            if (wr_trace[i] !== want) begin n_fail++; $display("FAIL stall_byte[%0d] got=%h want=%h", i, wr_trace[i], want); end
        end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL stall_frame_cnt got=%0d want=1", frame_cnt); end
        $display("test_full_stall: 5-cycle full stall after byte 2");
    endtask

    task automatic test_reset_mid();
        logic [8:0] want;
        reset_dut();
        iLeft = 24'h123456; iRight = 24'hABCDEF; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (3) step();
        RST = 1'b1;
        step();
        n_checks++; if (wr_trace[4] !== 9'h000) begin n_fail++; $display("FAIL midrst_write got=%h want=000", wr_trace[4]); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b want=0", busy); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_frame_cnt got=%0d want=0", frame_cnt); end
        RST = 1'b0;
        step();
        iLeft = 24'hC0FFEE; iRight = 24'h000001; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 13; i++) begin
            if (i < 4)       want = {1'b1, exp_a[i]};
            else if (i < 6)  want = 9'h000;
            else if (i < 12) want = {1'b1, exp_c[i-6]};
            else             want = 9'h000;
            n_checks++;
            if (wr_trace[i] !== want) begin n_fail++; $display("FAIL midrst_byte[%0d] got=%h want=%h", i, wr_trace[i], want); end
        end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_frame_cnt_after got=%0d want=1", frame_cnt); end
        $display("test_reset_mid: partial frame abandoned, next frame clean");
    endtask

    task automatic test_enable_drop();
        logic [8:0] want;
        reset_dut();
        iLeft = 24'h123456; iRight = 24'hABCDEF; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        step();
        iLeft = 24'h654321; iRight = 24'h0FEDCB; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        enable = 1'b0;
        repeat (6) step();
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL endrop_busy got=%b want=0", busy); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL endrop_frame_cnt got=%0d want=1", frame_cnt); end
`ifdef I2S_PACKER_DROPCNT_EN
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL endrop_drop_cnt got=%0d want=0", drop_cnt); end
`endif
        enable = 1'b1;
        iLeft = 24'h123456; iRight = 24'hABCDEF; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 12; i++) begin
            if (i < 6)       want = {1'b1, exp_a[i]};
            else if (i < 11) want = 9'h000;
            else             want = {1'b1, exp_a[0]};
            n_checks++;
            if (wr_trace[i] !== want) begin n_fail++; $display("FAIL endrop_byte[%0d] got=%h want=%h", i, wr_trace[i], want); end
        end
        $display("test_enable_drop: held frame discarded, FSM back to idle");
    endtask

    task automatic test_random();
        int sel;
        reset_dut();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            RST          = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            sample_valid = ($urandom_range(0, 2) == 0);
            iLeft        = 24'($urandom);
            iRight       = 24'($urandom);
            fifo.full    = ($urandom_range(0, 3) == 0);
            sel          = int'($urandom_range(0, 3));
            case (sel)
                0:       fifo.wrnum = '0;
                1:       fifo.wrnum = 10'(DEPTH - 14);
                2:       fifo.wrnum = 10'(DEPTH - 13);
                default: fifo.wrnum = 10'($urandom_range(0, DEPTH));
            endcase
            step();
            n_checks++;
            if (fifo.write !== m_write) begin n_fail++; $display("FAIL rnd_write cyc=%0d got=%b want=%b", cyc, fifo.write, m_write); end
            if (m_write) begin
                n_checks++;
                if (fifo.oData !== m_odata) begin n_fail++; $display("FAIL rnd_odata cyc=%0d got=%h want=%h", cyc, fifo.oData, m_odata); end
            end
            n_checks++;
            if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, busy, m_busy); end
            n_checks++;
            if (frame_cnt !== m_fcnt) begin n_fail++; $display("FAIL rnd_frame_cnt cyc=%0d got=%0d want=%0d", cyc, frame_cnt, m_fcnt); end
`ifdef I2S_PACKER_DROPCNT_EN
            n_checks++;
            if (drop_cnt !== m_dcnt) begin n_fail++; $display("FAIL rnd_drop_cnt cyc=%0d got=%0d want=%0d", cyc, drop_cnt, m_dcnt); end
`endif
        end
        RST = 1'b0; enable = 1'b1; sample_valid = 1'b0; fifo.full = 1'b0; fifo.wrnum = '0;
        $display("test_random: 3000 cycles, model frame_cnt=%0d", m_fcnt);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_no_space();
        test_full_stall();
        test_reset_mid();
        test_enable_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
